mesh_wormhole_packetizer: RTL
=============================

// Module: mesh_wormhole_packetizer
// PURPOSE
//  Network-interface transmitter feeding one input channel of a mesh wormhole node.
//  Accepts a packet descriptor (destination row/col, length) plus a stream of data words from the
//  local PE, and emits a wormhole worm: HEADER flit, PAYLOAD flits, then a TAIL flit.
//  Sits between the PE and in_chan_data_i/in_chan_vld_i/in_chan_rdy_o of the local node port.
// PARAMETERS
//  FLIT_DATA_W  8      flit data field width
//  FLIT_ID_W    2      flit type field width
//  ROW_ADDR_W   2      destination row address width
//  COL_ADDR_W   2      destination column address width
//  LEN_W        4      packet length field width (data words per packet)
//  HEADER_ID    2'b10  type code of header flit
//  PAYLOAD_ID   2'b01  type code of payload flit
//  TAIL_ID      2'b11  type code of tail flit
//  FLIT_W       FLIT_ID_W+FLIT_DATA_W  flit width (derived; do not override)
//  Constraint: ROW_ADDR_W+COL_ADDR_W <= FLIT_DATA_W.
// PORTS
//  clk_i        in   1            clock
//  rst_ni       in   1            asynchronous active-low reset
//  pkt_vld_i    in   1            packet descriptor valid
//  pkt_rdy_o    out  1            descriptor accepted when pkt_vld_i & pkt_rdy_o
//  pkt_row_i    in   ROW_ADDR_W   destination row
//  pkt_col_i    in   COL_ADDR_W   destination column
//  pkt_len_i    in   LEN_W        number of data words (1..2^LEN_W-1)
//  data_i       in   FLIT_DATA_W  data word
//  data_vld_i   in   1            data word valid
//  data_rdy_o   out  1            data accepted when data_vld_i & data_rdy_o
//  flit_o       out  FLIT_W       flit to node input channel, {id, data}
//  flit_vld_o   out  1            flit valid (node FIFO wr_en)
//  flit_rdy_i   in   1            node FIFO not full; flit consumed when flit_vld_o & flit_rdy_i
//  busy_o       out  1            high while in BODY state
//  err_len_o    out  1            one-cycle pulse: zero-length descriptor dropped
// BEHAVIOUR
//  Reset (async, rst_ni=0): state=IDLE, remaining count=0, flit_o=0, flit_vld_o=0, err_len_o=0,
//   busy_o=0. Outputs update on clk_i rising edge only after rst_ni deasserts.
//  Output register: single flit stage; free = !flit_vld_o | flit_rdy_i. flit_o/flit_vld_o held
//   stable while flit_vld_o & !flit_rdy_i. Consumed without reload -> flit_vld_o=0 next cycle.
//  IDLE: pkt_rdy_o = free; data_rdy_o=0. On descriptor accept with len>=1: flit_o <=
//   {HEADER_ID, zero-ext {pkt_row_i, pkt_col_i}} (col in LSBs), flit_vld_o<=1, cnt<=len, ->BODY.
//   Accept with len==0: no flit, err_len_o pulses next cycle, stay IDLE.
//  BODY: pkt_rdy_o=0; data_rdy_o = free. On data accept: flit_o <= {cnt==1 ? TAIL_ID :
//   PAYLOAD_ID, data_i}, flit_vld_o<=1, cnt<=cnt-1; if cnt==1 -> IDLE.
//  Latency: flit registered 1 cycle after its accepting handshake; throughput 1 flit/cycle with
//   flit_rdy_i=1. Worm of len N = N+1 flits; len 1 = HEADER then TAIL. No bubble between a TAIL
//   and the next HEADER (IDLE accepts descriptor while TAIL is being consumed).
//  Data words arriving in IDLE are not accepted (data_rdy_o=0); descriptors in BODY wait.
//  Worm is never interleaved; node routers rely on HEADER..TAIL contiguity.
//  Reset mid-packet: worm truncated, no TAIL emitted; node must be reset in same domain.
//  rdy outputs are combinational from flit_rdy_i/state; no combinational path from vld to rdy.
// TESTING
//  Reset asserted mid-stream -> flit_vld_o=0, busy_o=0, pkt_rdy_o=1 (flit_rdy_i=1), data_rdy_o=0.
//  row=1,col=2,len=3, data A1,A2,A3, flit_rdy_i=1 -> flits 10'h206,10'h1A1,10'h1A2,10'h3A3 on
//   4 consecutive cycles, header 1 cycle after descriptor accept.
//  len=1, data 5C -> exactly 10'h2xx header then 10'h35C tail; back to IDLE.
//  flit_rdy_i=0 for 3 cycles holding payload 10'h1A2 -> flit_o stable, data_rdy_o=0, no loss/dup.
//  len=0 descriptor -> accepted, err_len_o one-cycle pulse, flit_vld_o stays 0.
//  Two back-to-back packets, flit_rdy_i=1 -> second HEADER in cycle right after first TAIL.

Source files
------------

// File: rtl/mesh_wormhole_packetizer.sv
// Network-interface transmitter: turns a packet descriptor plus a stream of data words into a
// HEADER / PAYLOAD... / TAIL wormhole worm through a single registered flit stage.
module mesh_wormhole_packetizer #(
    parameter int                   FLIT_DATA_W = 8,
    parameter int                   FLIT_ID_W   = 2,
    parameter int                   ROW_ADDR_W  = 2,
    parameter int                   COL_ADDR_W  = 2,
    parameter int                   LEN_W       = 4,
    parameter logic [FLIT_ID_W-1:0] HEADER_ID   = 2'b10,
    parameter logic [FLIT_ID_W-1:0] PAYLOAD_ID  = 2'b01,
    parameter logic [FLIT_ID_W-1:0] TAIL_ID     = 2'b11,
    localparam int                  FLIT_W      = FLIT_ID_W + FLIT_DATA_W
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   pkt_vld_i,
    output logic                   pkt_rdy_o,
    input  logic [ROW_ADDR_W-1:0]  pkt_row_i,
    input  logic [COL_ADDR_W-1:0]  pkt_col_i,
    input  logic [LEN_W-1:0]       pkt_len_i,
    input  logic [FLIT_DATA_W-1:0] data_i,
    input  logic                   data_vld_i,
    output logic                   data_rdy_o,
    output logic [FLIT_W-1:0]      flit_o,
    output logic                   flit_vld_o,
    input  logic                   flit_rdy_i,
    output logic                   busy_o,
    output logic                   err_len_o
);

    localparam int ADDR_W = ROW_ADDR_W + COL_ADDR_W;
    localparam logic [LEN_W-1:0] CNT_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BODY = 1'b1
    } state_t;

    state_t                   state_r, state_s;
    logic [LEN_W-1:0]         cnt_r, cnt_s;
    logic [FLIT_W-1:0]        flit_r, flit_s;
    logic                     vld_r, vld_s;
    logic                     err_r, err_s;
    logic                     busy_r, busy_s;
    logic                     free_s;
    logic                     pkt_acc_s;
    logic                     data_acc_s;
    logic [FLIT_DATA_W-1:0]   header_data_s;

    // The output stage can take a new flit when empty or when its current flit leaves this cycle
    assign free_s     = !vld_r || flit_rdy_i;
    assign pkt_rdy_o  = (state_r == ST_IDLE) && free_s;
    assign data_rdy_o = (state_r == ST_BODY) && free_s;
    assign pkt_acc_s  = pkt_vld_i && pkt_rdy_o;
    assign data_acc_s = data_vld_i && data_rdy_o;

    assign flit_o     = flit_r;
    assign flit_vld_o = vld_r;
    assign err_len_o  = err_r;
    assign busy_o     = busy_r;

    // Header payload: destination address zero-extended, column in the LSBs
    always_comb begin
        header_data_s              = {FLIT_DATA_W{1'b0}};
        header_data_s[ADDR_W-1:0]  = {pkt_row_i, pkt_col_i};
    end

    // Next-state and output-stage load logic
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        flit_s  = flit_r;
        vld_s   = vld_r && !flit_rdy_i;
        err_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pkt_acc_s) begin
                    if (pkt_len_i == CNT_ZERO) begin
                        err_s = 1'b1;
                    end else begin
                        flit_s  = {HEADER_ID, header_data_s};
                        vld_s   = 1'b1;
                        cnt_s   = pkt_len_i;
                        state_s = ST_BODY;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_BODY: begin
                if (data_acc_s) begin
                    flit_s = {(cnt_r == CNT_ONE) ? TAIL_ID : PAYLOAD_ID, data_i};
                    vld_s  = 1'b1;
                    cnt_s  = cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ONE) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = ST_BODY;
                    end
                end else begin
                    state_s = ST_BODY;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = CNT_ZERO;
                vld_s   = 1'b0;
            end
        endcase
        busy_s = (state_s == ST_BODY);
    end

    // State, remaining-word count and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            flit_r  <= {FLIT_W{1'b0}};
            vld_r   <= 1'b0;
            err_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            flit_r  <= flit_s;
            vld_r   <= vld_s;
            err_r   <= err_s;
            busy_r  <= busy_s;
        end
    end

endmodule
